// File: rtl/uart_reg_pkg.sv
// uart_reg_pkg: shared constants for the UART APB register file.
//   - register byte addresses (word aligned)
//   - LCR and FSR bit positions
//   - register reset values
//   - APB handshake FSM state encoding
package uart_reg_pkg;

    localparam logic [7:0] ADDR_TBR = 8'h00;
    localparam logic [7:0] ADDR_RBR = 8'h04;
    localparam logic [7:0] ADDR_DLL = 8'h08;
    localparam logic [7:0] ADDR_DLH = 8'h0C;
    localparam logic [7:0] ADDR_LCR = 8'h10;
    localparam logic [7:0] ADDR_IER = 8'h14;
    localparam logic [7:0] ADDR_FSR = 8'h18;

    // LCR = {1'b0, OSM_SEL, BGE, EPS, PEN, STB, WLS[1:0]}
    localparam int LCR_WLS_LSB = 0;
    localparam int LCR_STB     = 2;
    localparam int LCR_PEN     = 3;
    localparam int LCR_EPS     = 4;
    localparam int LCR_BGE     = 5;
    localparam int LCR_OSM     = 6;

    // FSR = {4'b0, rx_empty, rx_full, tx_empty, tx_full}
    localparam int FSR_TX_FULL  = 0;
    localparam int FSR_TX_EMPTY = 1;
    localparam int FSR_RX_FULL  = 2;
    localparam int FSR_RX_EMPTY = 3;

    localparam logic [7:0] DLL_RST = 8'h01;
    localparam logic [7:0] DLH_RST = 8'h00;
    localparam logic [6:0] LCR_RST = 7'h03;
    localparam logic [3:0] IER_RST = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_t;

endpackage

// File: rtl/uart_apb_fsm.sv
// uart_apb_fsm: APB3 handshake sequencer giving every transfer one wait state.
//   clk, rst  clock, asynchronous active-high reset
//   psel      APB select
//   penable   APB access phase
//   go        1 in WAIT when the access phase is present: decode/latch now,
//             side effects become visible in the following DONE cycle
//   done      1 in DONE (drives pready)
//   state     current state, exposed for debug/checkers
module uart_apb_fsm
    import uart_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       psel,
    input  logic       penable,
    output logic       go,
    output logic       done,
    output apb_state_t state
);

    apb_state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        go         = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Dropping psel abandons the transfer without any side effect.
                if (!psel) begin
                    state_next = IDLE;
                end else if (penable) begin
                    go         = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_apb_regs.sv
// uart_apb_regs: APB3 slave register file in front of the UART core.
//   APB side : psel, penable, pwrite, paddr, pwdata -> prdata, pready, pslverr
//   Core side: RBR_i/FSR_i in; TBR_o + tx_flag (push), rx_flag (pop),
//              DLL/DLH divisor, LCR fields, IER enables out.
// Optional feature macro: UART_APB_PSLVERR_EN -- when defined, pslverr flags
//   unmapped addresses, writes to RBR/FSR, TBR reads, TBR write while TX full
//   and RBR read while RX empty. When undefined pslverr is tied low.
// Side effects (register commit, tx_flag, rx_flag) are computed in WAIT and
// registered, so they are visible exactly in the DONE cycle alongside pready.
module uart_apb_regs
    import uart_reg_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [7:0]        RBR_i,
    input  logic [7:0]        FSR_i,
    output logic [7:0]        TBR_o,
    output logic              tx_flag,
    output logic              rx_flag,
    output logic [7:0]        DLL,
    output logic [7:0]        DLH,
    output logic [1:0]        WLS,
    output logic              STB,
    output logic              PEN,
    output logic              EPS,
    output logic              BGE,
    output logic              OSM_SEL,
    output logic              en_tx_fifo_empty,
    output logic              en_tx_fifo_full,
    output logic              en_rx_fifo_empty,
    output logic              en_rx_fifo_full
);

    logic              go;
    logic              done;
    apb_state_t        fsm_state;
    logic [ADDR_W-1:0] word_addr;
    logic [6:0]        lcr;
    logic [3:0]        ier;
    logic              err_q;

    logic hit_tbr, hit_rbr, hit_dll, hit_dlh, hit_lcr, hit_ier, hit_fsr, mapped;
    logic tx_push, rx_pop, err;
    logic [7:0] rd_data;

    uart_apb_fsm u_fsm (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel),
        .penable (penable),
        .go      (go),
        .done    (done),
        .state   (fsm_state)
    );

    assign word_addr = {paddr[ADDR_W-1:2], 2'b00};
    assign hit_tbr   = (word_addr == ADDR_W'(ADDR_TBR));
    assign hit_rbr   = (word_addr == ADDR_W'(ADDR_RBR));
    assign hit_dll   = (word_addr == ADDR_W'(ADDR_DLL));
    assign hit_dlh   = (word_addr == ADDR_W'(ADDR_DLH));
    assign hit_lcr   = (word_addr == ADDR_W'(ADDR_LCR));
    assign hit_ier   = (word_addr == ADDR_W'(ADDR_IER));
    assign hit_fsr   = (word_addr == ADDR_W'(ADDR_FSR));
    assign mapped    = hit_tbr | hit_rbr | hit_dll | hit_dlh | hit_lcr | hit_ier | hit_fsr;

    always_comb begin
        rd_data = 8'h00;
        if (hit_rbr) rd_data = RBR_i;
        if (hit_dll) rd_data = DLL;
        if (hit_dlh) rd_data = DLH;
        if (hit_lcr) rd_data = {1'b0, lcr};
        if (hit_ier) rd_data = {4'b0, ier};
        if (hit_fsr) rd_data = FSR_i;
    end

    // A push into a full TX FIFO or a pop from an empty RX FIFO is dropped.
    assign tx_push = pwrite & hit_tbr & ~FSR_i[FSR_TX_FULL];
    assign rx_pop  = ~pwrite & hit_rbr & ~FSR_i[FSR_RX_EMPTY];
    assign err     = ~mapped
                   | (pwrite & (hit_rbr | hit_fsr))
                   | (~pwrite & hit_tbr)
                   | (pwrite & hit_tbr & FSR_i[FSR_TX_FULL])
                   | (~pwrite & hit_rbr & FSR_i[FSR_RX_EMPTY]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prdata  <= 32'h0;
            tx_flag <= 1'b0;
            rx_flag <= 1'b0;
            err_q   <= 1'b0;
            TBR_o   <= 8'h00;
            DLL     <= DLL_RST;
            DLH     <= DLH_RST;
            lcr     <= LCR_RST;
            ier     <= IER_RST;
        end else begin
            tx_flag <= 1'b0;
            rx_flag <= 1'b0;
            err_q   <= 1'b0;
            if (go) begin
                prdata  <= pwrite ? 32'h0 : {24'h0, rd_data};
                tx_flag <= tx_push;
                rx_flag <= rx_pop;
                err_q   <= err;
                if (tx_push) TBR_o <= pwdata[7:0];
                if (pwrite && hit_dll) DLL <= pwdata[7:0];
                if (pwrite && hit_dlh) DLH <= pwdata[7:0];
                if (pwrite && hit_lcr) lcr <= pwdata[6:0];
                if (pwrite && hit_ier) ier <= pwdata[3:0];
            end
        end
    end

    assign pready = done;

`ifdef UART_APB_PSLVERR_EN
    assign pslverr = err_q;
`else
    assign pslverr = 1'b0;
`endif

    assign WLS     = lcr[LCR_WLS_LSB +: 2];
    assign STB     = lcr[LCR_STB];
    assign PEN     = lcr[LCR_PEN];
    assign EPS     = lcr[LCR_EPS];
    assign BGE     = lcr[LCR_BGE];
    assign OSM_SEL = lcr[LCR_OSM];

    assign en_tx_fifo_empty = ier[0];
    assign en_tx_fifo_full  = ier[1];
    assign en_rx_fifo_empty = ier[2];
    assign en_rx_fifo_full  = ier[3];

    // Bits intentionally not consumed: upper write data, byte offset, debug state,
    // FSR bits the register file never acts on, and err_q in the tied-off build.
    logic unused_ok;
    assign unused_ok = ^{pwdata[31:8], paddr[1:0], fsm_state, err_q,
                         FSR_i[FSR_TX_EMPTY], FSR_i[FSR_RX_FULL]};

endmodule
